ula_sequencial: RTL

Parametrised sequential ALU for the processor datapath. It generalises the 8-bit add/subtract unit to `LARGURA` bits with an 8-operation set, full flag generation and a start/valid handshake. Logic operations complete in one cycle. Multiply and divide run as iterative multi-cycle operations. The control FSM stalls on `ocupado` and captures results on `valido`.

---
 rtl/ula_sequencial.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ula_sequencial.sv
// Sequential ALU: single-cycle add/sub/logic/slt, iterative shift-add multiply and restoring divide.
// Define ULA_DIVISAO_EN to build the divider; otherwise opcode 111 reports erro_div in one cycle.
module ula_sequencial #(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               inicio,
  input  logic [2:0]         controle_ula,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  output logic [LARGURA-1:0] saida_ula,
  output logic [LARGURA-1:0] resto,
  output logic               valido,
  output logic               ocupado,
  output logic               zero,
  output logic               negativo,
  output logic               carry,
  output logic               overflow,
  output logic               erro_div
);

  localparam int CW = $clog2(LARGURA + 1);

  typedef enum logic [1:0] {OCIOSO, CALCULA, CONCLUI} estado_t;

  estado_t            estado, proximo;
  logic [CW-1:0]      contador;
  logic               aceita, iterativa;

  logic [LARGURA-1:0] hi_p1, lo_p1, op_b_p1;
  logic [LARGURA-1:0] hi_p0, lo_p0;
  logic [LARGURA:0]   parcial;
`ifdef ULA_DIVISAO_EN
  logic               op_div_p1;
  logic [LARGURA:0]   desloc;
`endif

  logic [LARGURA-1:0] res_s, res_r;
  logic [LARGURA:0]   soma, dif;
  logic signed [LARGURA-1:0] a_s, b_s;
  logic               f_c, f_v, f_e, f_n_en;

  function automatic logic estouro(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  always_comb begin
`ifdef ULA_DIVISAO_EN
    iterativa = (controle_ula == 3'b110) || ((controle_ula == 3'b111) && (b != '0));
`else
    iterativa = (controle_ula == 3'b110);
`endif
    aceita = inicio && (estado != CALCULA);
  end

  // single-cycle result path
  always_comb begin
    soma   = {1'b0, a} + {1'b0, b};
    dif    = {1'b0, a} - {1'b0, b};
    a_s    = $signed(a);
    b_s    = $signed(b);
    res_s  = '0;
    res_r  = '0;
    f_c    = 1'b0;
    f_v    = 1'b0;
    f_e    = 1'b0;
    f_n_en = 1'b1;
    case (controle_ula)
      3'b000: begin
        res_s = soma[LARGURA-1:0];
        f_c   = soma[LARGURA];
        f_v   = estouro(a[LARGURA-1], b[LARGURA-1], soma[LARGURA-1]);
      end
      3'b001: begin
        res_s = dif[LARGURA-1:0];
        f_c   = dif[LARGURA];
        f_v   = estouro(a[LARGURA-1], ~b[LARGURA-1], dif[LARGURA-1]);
      end
      3'b010: res_s = a & b;
      3'b011: res_s = a | b;
      3'b100: res_s = a ^ b;
      3'b101: res_s = {{(LARGURA-1){1'b0}}, (a_s < b_s)};
      3'b111: begin
        f_e    = 1'b1;
        f_n_en = 1'b0;
`ifdef ULA_DIVISAO_EN
        res_s  = '1;
        res_r  = a;
`endif
      end
      default: f_n_en = 1'b0;
    endcase
  end

  // one iteration step: shift-add multiply, restoring divide
  always_comb begin
    parcial = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, op_b_p1} : '0);
    hi_p0   = parcial[LARGURA:1];
    lo_p0   = {parcial[0], lo_p1[LARGURA-1:1]};
`ifdef ULA_DIVISAO_EN
    desloc  = {hi_p1, lo_p1[LARGURA-1]};
    if (op_div_p1) begin
      if (desloc >= {1'b0, op_b_p1}) begin
        parcial = desloc - {1'b0, op_b_p1};
        hi_p0   = parcial[LARGURA-1:0];
        lo_p0   = {lo_p1[LARGURA-2:0], 1'b1};
      end else begin
        hi_p0   = desloc[LARGURA-1:0];
        lo_p0   = {lo_p1[LARGURA-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= OCIOSO;
    else          estado <= proximo;
  end

  always_comb begin
    proximo = OCIOSO;
    case (estado)
      CALCULA: proximo = (contador == CW'(1)) ? CONCLUI : CALCULA;
      default: proximo = (aceita && iterativa) ? CALCULA : OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado == CALCULA);
  end

  always_ff @(posedge clock) begin
    if (aceita && iterativa) begin
      hi_p1     <= '0;
      lo_p1     <= a;
      op_b_p1   <= b;
`ifdef ULA_DIVISAO_EN
      op_div_p1 <= controle_ula[0];
`endif
    end else if (estado == CALCULA) begin
      hi_p1 <= hi_p0;
      lo_p1 <= lo_p0;
    end
  end

  // results and flags; the final iteration writes them directly so valido lands in CONCLUI
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contador  <= '0;
      saida_ula <= '0;
      resto     <= '0;
      valido    <= 1'b0;
      zero      <= 1'b0;
      negativo  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      erro_div  <= 1'b0;
    end else begin
      valido <= 1'b0;
      if (estado == CALCULA) begin
        contador <= contador - CW'(1);
        if (contador == CW'(1)) begin
          saida_ula <= lo_p0;
          resto     <= hi_p0;
          zero      <= (lo_p0 == '0);
          negativo  <= 1'b0;
          overflow  <= 1'b0;
          erro_div  <= 1'b0;
`ifdef ULA_DIVISAO_EN
          carry     <= !op_div_p1 && (hi_p0 != '0);
`else
          carry     <= (hi_p0 != '0);
`endif
          valido    <= 1'b1;
        end
      end else if (aceita) begin
        if (iterativa) begin
          contador <= CW'(LARGURA);
        end else begin
          saida_ula <= res_s;
          resto     <= res_r;
          zero      <= (res_s == '0);
          negativo  <= f_n_en & res_s[LARGURA-1];
          carry     <= f_c;
          overflow  <= f_v;
          erro_div  <= f_e;
          valido    <= 1'b1;
        end
      end
    end
  end

endmodule
